// File: rtl/serial_adder_if.sv
// serial_adder_if: operand/handshake/result bundle for serial_adder; sub exists only with SERIAL_ADDER_SUB_EN.
interface serial_adder_if #(parameter int WIDTH = 8);
  logic start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic sub;
`endif
  logic busy;
  logic done;
  logic [WIDTH-1:0] sum;
  logic carry;
  logic overflow;
  modport master (
`ifdef SERIAL_ADDER_SUB_EN
    output sub,
`endif
    output start, a, b, cin,
    input busy, done, sum, carry, overflow
  );
  modport slave (
`ifdef SERIAL_ADDER_SUB_EN
    input sub,
`endif
    input start, a, b, cin,
    output busy, done, sum, carry, overflow
  );
endinterface

// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder, one full-add cell and carry flop; SERIAL_ADDER_SUB_EN adds a - b - cin mode.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic reset,
  serial_adder_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_next;
  logic [WIDTH-1:0] a_sh, b_sh, s_sh, sum_q;
  logic [CW-1:0] cnt;
  logic c, carry_q, ovf_q;
  logic s, c_next, last, accept, inv;
`ifdef SERIAL_ADDER_SUB_EN
  assign inv = bus.sub;
`else
  assign inv = 1'b0;
`endif
  always_comb begin
    s = a_sh[0] ^ b_sh[0] ^ c;
    c_next = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
    last = cnt == CW'(WIDTH - 1);
    accept = bus.start && state != RUN;
    state_next = accept ? RUN : (state == RUN) ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      a_sh <= '0;
      b_sh <= '0;
      s_sh <= '0;
      c <= 1'b0;
      cnt <= '0;
      sum_q <= '0;
      carry_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        a_sh <= bus.a;
        b_sh <= bus.b ^ {WIDTH{inv}};
        c <= bus.cin ^ inv;
        cnt <= '0;
      end else if (state == RUN) begin
        a_sh <= a_sh >> 1;
        b_sh <= b_sh >> 1;
        s_sh <= {s, s_sh[WIDTH-1:1]};
        c <= c_next;
        cnt <= last ? cnt : cnt + 1'b1;
        // c here is still the carry into the MSB, so overflow is c ^ carry-out
        if (last) begin
          sum_q <= {s, s_sh[WIDTH-1:1]};
          carry_q <= c_next;
          ovf_q <= c ^ c_next;
        end
      end
    end
  end
  assign bus.busy = state == RUN;
  assign bus.done = state == DONE;
  assign bus.sum = sum_q;
  assign bus.carry = carry_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed scoreboard bench for serial_adder (WIDTH=8); sub tests build with SERIAL_ADDER_SUB_EN.
module tb_serial_adder;
  localparam int W = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [W+1:0] sb[$];
  logic [W+1:0] last_res = '0;
  serial_adder_if #(.WIDTH(W)) bus ();
  serial_adder #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input logic sub);
    logic [W-1:0] bb;
    logic [W:0] full;
    logic ovf;
    bb = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, ci ^ sub};
    ovf = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
    return {full[W-1:0], full[W], ovf};
  endfunction

  // Called on a negedge; returns on the negedge where done is seen.
  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input logic sub, input logic jam);
    int lat;
    int busy_n;
    sb.push_back(model(a, b, ci, sub));
    bus.start = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.cin = ci;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub = sub;
`endif
    @(negedge clk);
    bus.start = jam;
    chk("done_low_after_accept", {31'd0, bus.done}, 0);
    lat = 0;
    busy_n = 0;
    while (!bus.done && lat < 20) begin
      if (bus.busy) busy_n++;
      chk("outputs_held", {22'd0, bus.sum, bus.carry, bus.overflow}, {22'd0, last_res});
      bus.a = W'($urandom);
      bus.b = W'($urandom);
      bus.cin = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    chk("latency", lat, W);
    chk("busy_cycles", busy_n, W);
    chk("busy_low_in_done", {31'd0, bus.busy}, 0);
    chk("scoreboard_nonempty", (sb.size() > 0) ? 1 : 0, 1);
    if (sb.size() > 0) last_res = sb.pop_front();
    chk("result", {22'd0, bus.sum, bus.carry, bus.overflow}, {22'd0, last_res});
  endtask

  initial begin
    int seen_done;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("reset_outputs", {19'd0, bus.busy, bus.done, bus.sum, bus.carry, bus.overflow}, 0);
    reset = 1'b0;
    @(negedge clk);
    op(8'h35, 8'h4A, 1'b0, 1'b0, 1'b0);
    chk("basic_sum", {24'd0, bus.sum}, 32'h7F);
    @(negedge clk);
    op(8'h0F, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("cin_sum", {24'd0, bus.sum}, 32'h10);
    @(negedge clk);
    op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    chk("wrap_carry", {31'd0, bus.carry}, 1);
    @(negedge clk);
    op(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
    chk("signed_ovf", {31'd0, bus.overflow}, 1);
    @(negedge clk);
    op(8'hA5, 8'h3C, 1'b1, 1'b0, 1'b1);
    op(8'h01, 8'h02, 1'b0, 1'b0, 1'b0);
    chk("back_to_back_sum", {24'd0, bus.sum}, 32'h03);
    @(negedge clk);
    op(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 8'h55;
    bus.b = 8'h11;
    bus.cin = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    last_res = '0;
    chk("reset_midop_outputs", {19'd0, bus.busy, bus.done, bus.sum, bus.carry, bus.overflow}, 0);
    seen_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) seen_done = 1;
    end
    chk("no_done_after_abort", seen_done, 0);
    op(8'h10, 8'h20, 1'b0, 1'b0, 1'b0);
    chk("post_reset_sum", {24'd0, bus.sum}, 32'h30);
`ifdef SERIAL_ADDER_SUB_EN
    @(negedge clk);
    op(8'h10, 8'h20, 1'b0, 1'b1, 1'b0);
    chk("sub_sum", {24'd0, bus.sum}, 32'hF0);
    @(negedge clk);
    op(8'h80, 8'h01, 1'b0, 1'b1, 1'b0);
    chk("sub_ovf", {22'd0, bus.sum, bus.carry, bus.overflow}, {22'd0, 8'h7F, 2'b11});
    @(negedge clk);
    op(8'h33, 8'h11, 1'b1, 1'b1, 1'b0);
`endif
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
